pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline stall/flush controller for the in-order CPU core; successor to the fixed 5-bit stall priority encoder.
- Merges any number of per-stage stall requests into a prefix stall mask and derives bubble-insert bits.
- Sequences exception/redirect flushes around full-pipeline freezes, such as AXI wait.
- Runs a stall watchdog.
- Sits beside the pipeline registers; every stage register consumes `stall[k]`/`bubble[k]`/`flush`.

Parameters:
- NUM_STAGES, 6, number of pipeline stages (index 0 = PC … NUM_STAGES-1 = WB); width of stall/bubble buses; must be ≥2.
- NUM_REQ, 4, number of stall request sources.
- PC_WIDTH, 32, redirect PC width.
- TIMEOUT, 1024, consecutive stall cycles before `stall_timeout` sets; 0 disables the watchdog.
- SW (localparam), clog2(NUM_STAGES), width of a stage index.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- stall_req  in  NUM_REQ  request i active.
- stall_stage  in  NUM_REQ*SW  request i stalls stages 0..stall_stage[i]; field i is bits [i*SW +: SW].
- excp_valid  in  1  exception/redirect request, single-cycle pulse.
- excp_pc  in  PC_WIDTH  redirect target, sampled with `excp_valid`.
- stall  out  NUM_STAGES  stage k holds its register.
- bubble  out  NUM_STAGES  stage k loads a NOP.
- flush  out  1  kill all in-flight instructions.
- new_pc  out  PC_WIDTH  redirect target, valid while `flush` = 1.
- excp_ack  out  1  one-cycle pulse: exception captured.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
Reset
- While `rst` = 1, all outputs are 0 and the FSM is in IDLE.
- `rst` asserting mid-stall or mid-flush drops everything immediately; the pending PC is discarded.

Stall mask (combinational)
- mask_i = (1<<(stall_stage[i]+1))-1 when `stall_req[i]`, else 0.
- raw_stall = OR of all mask_i, so the deepest request wins.
- A `stall_stage` field ≥ NUM_STAGES saturates to all-ones.
- freeze = raw_stall[NUM_STAGES-1].

Bubble (combinational)
- bubble[0] = 0.
- bubble[k] = stall[k-1] & ~stall[k] for k ≥ 1.
- bubble = 0 while `flush` = 1.

FSM: IDLE, PEND, FLUSH (registered)
- IDLE, `excp_valid`, freeze = 0 → FLUSH. Latch `excp_pc`; `excp_ack` = 1 next cycle.
- IDLE, `excp_valid`, freeze = 1 → PEND. Latch `excp_pc`; `excp_ack` = 1 next cycle.
- PEND, freeze = 1 → stay in PEND.
- PEND, freeze = 0 → FLUSH.
- FLUSH, freeze = 0 → IDLE. `flush` = 1 and `new_pc` = latched PC for this cycle.
- FLUSH, freeze = 1 → stay in FLUSH, holding `flush` and `new_pc` until a freeze-free cycle.
- `excp_valid` while in PEND or FLUSH is ignored: the oldest exception wins and there is no ack.
- `excp_valid` in the same cycle the FSM returns to IDLE is ignored.

Stall output
- In FLUSH: stall = all-ones if freeze, else 0. Flushed stages' requests are dropped.
- Otherwise: stall = raw_stall.

Flush latency
- 1 cycle from `excp_valid` to `flush` when unfrozen.
- Otherwise, the cycle after freeze deasserts.

Watchdog
- SW-independent counter of width clog2(TIMEOUT+1).
- Increments each cycle stall ≠ 0; clears on any cycle stall = 0; saturates at TIMEOUT.
- Reaching TIMEOUT sets `stall_timeout`, which stays 1 until `rst`.

Test Plan:
- Defaults; req0 stage 2 and req1 stage 4 together → stall = 6'b011111, bubble = 6'b100000. Drop req1 → stall = 6'b000111, bubble = 6'b001000.
- `excp_valid` with excp_pc = 0xBFC00380, no stalls → next cycle `flush` = 1, `new_pc` = 0xBFC00380, `excp_ack` = 1, bubble = 0, for one cycle only.
- Freeze request (stage 5) held for 3 cycles; `excp_valid` in cycle 0 → `excp_ack` in cycle 1, stall = 6'b111111 throughout. `flush` asserts for 1 cycle on the first cycle after freeze drops.
- In PEND, second `excp_valid` with PC 0x1234 → no ack; the flush later carries the first PC.
- TIMEOUT = 8; stall held for 7 cycles → `stall_timeout` = 0. A 1-cycle gap resets the count. Then hold 8 cycles → `stall_timeout` = 1, and it stays 1 after stall releases.
- `rst` pulsed asynchronously while in PEND → all outputs 0 immediately. After release, freeze drops → no flush.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges per-stage stall requests into a prefix
// stall mask, sequences exception flushes around full freezes, and runs a stall watchdog.
module pipe_hazard_ctrl #(
    parameter int unsigned NUM_STAGES = 6,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     stall_req,
    input  logic [NUM_REQ*$clog2(NUM_STAGES)-1:0]  stall_stage,
    input  logic                                   excp_valid,
    input  logic [PC_WIDTH-1:0]                    excp_pc,
    output logic [NUM_STAGES-1:0]                  stall,
    output logic [NUM_STAGES-1:0]                  bubble,
    output logic                                   flush,
    output logic [PC_WIDTH-1:0]                    new_pc,
    output logic                                   excp_ack,
    output logic                                   stall_timeout
);

    localparam int unsigned SW = $clog2(NUM_STAGES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PEND  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  ack_q;
    logic                  capture;
    logic [NUM_STAGES-1:0] raw_stall;
    logic                  freeze;

    // A stage index >= NUM_STAGES naturally covers every stage, giving the saturation.
    always_comb begin : merge_requests
        int unsigned sel;
        raw_stall = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = 32'(stall_stage[i*SW +: SW]);
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (stall_req[i] && (k <= sel)) begin
                    raw_stall[k] = 1'b1;
                end
            end
        end
    end

    assign freeze = raw_stall[NUM_STAGES-1];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (excp_valid) begin
                    capture = 1'b1;
                    state_d = freeze ? S_PEND : S_FLUSH;
                end
            end
            S_PEND:  if (!freeze) state_d = S_FLUSH;
            S_FLUSH: if (!freeze) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= capture;
            if (capture) begin
                pc_q <= excp_pc;
            end
        end
    end

    assign flush    = (state_q == S_FLUSH);
    assign new_pc   = flush ? pc_q : '0;
    assign excp_ack = ack_q;

    // Requests from stages being flushed are dropped; only a freeze still holds everything.
    always_comb begin
        if (rst) begin
            stall = '0;
        end else if (flush) begin
            stall = {NUM_STAGES{freeze}};
        end else begin
            stall = raw_stall;
        end
    end

    assign bubble = flush ? '0 : ({stall[NUM_STAGES-2:0], 1'b0} & ~stall);

    if (TIMEOUT > 0) begin : g_watchdog
        localparam int unsigned CW = $clog2(TIMEOUT + 1);
        logic [CW-1:0] cnt_q;
        logic          timeout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q     <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (stall == '0) begin
                    cnt_q <= '0;
                end else if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                if ((stall != '0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                    timeout_q <= 1'b1;
                end
            end
        end

        assign stall_timeout = timeout_q;
    end else begin : g_no_watchdog
        assign stall_timeout = 1'b0;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver pushes reference-model expectations,
// a mid-cycle monitor pops and compares them against the DUT outputs.
module tb_pipe_hazard_ctrl;

    localparam int NS  = 6;
    localparam int NR  = 4;
    localparam int PW  = 32;
    localparam int TO  = 8;
    localparam int SWB = 3;

    typedef struct {
        logic [NS-1:0] stall;
        logic [NS-1:0] bubble;
        logic          flush;
        logic [PW-1:0] new_pc;
        logic          ack;
        logic          tmo;
        int            cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     stall_req = '0;
    logic [NR*SWB-1:0] stall_stage = '0;
    logic              excp_valid = 1'b0;
    logic [PW-1:0]     excp_pc = '0;
    logic [NS-1:0]     stall, bubble;
    logic              flush, excp_ack, stall_timeout;
    logic [PW-1:0]     new_pc;

    pipe_hazard_ctrl #(
        .NUM_STAGES(NS),
        .NUM_REQ(NR),
        .PC_WIDTH(PW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall_req(stall_req),
        .stall_stage(stall_stage),
        .excp_valid(excp_valid),
        .excp_pc(excp_pc),
        .stall(stall),
        .bubble(bubble),
        .flush(flush),
        .new_pc(new_pc),
        .excp_ack(excp_ack),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    // Reference model state: an accepted exception waits for two freeze-free cycles,
    // the first releases the flush, the second retires it.
    bit           m_pending   = 0;
    int           m_free_seen = 0;
    logic [PW-1:0] m_pc       = '0;
    bit           m_ack_next  = 0;
    int           m_run       = 0;
    bit           m_sticky    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int cyc);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
        end
    endtask

    function automatic logic [NR*SWB-1:0] stg(input int a, input int b, input int c, input int d);
        logic [NR*SWB-1:0] r;
        r[2:0]  = a[2:0];
        r[5:3]  = b[2:0];
        r[8:6]  = c[2:0];
        r[11:9] = d[2:0];
        return r;
    endfunction

    task automatic step(input logic [NR-1:0] req, input logic [NR*SWB-1:0] st,
                        input logic ev, input logic [PW-1:0] pc, input logic r);
        exp_t e;
        int   raw, s;
        bit   frz, fl;
        @(posedge clk);
        #1;
        cycle++;
        rst         = r;
        stall_req   = req;
        stall_stage = st;
        excp_valid  = ev;
        excp_pc     = pc;
        e.cyc = cycle;
        if (r) begin
            e.stall = '0; e.bubble = '0; e.flush = 0; e.new_pc = '0; e.ack = 0; e.tmo = 0;
            m_pending = 0; m_free_seen = 0; m_ack_next = 0; m_run = 0; m_sticky = 0;
        end else begin
            raw = 0;
            for (int i = 0; i < NR; i++) begin
                if (req[i]) begin
                    s = int'(st[i*SWB +: SWB]);
                    raw = raw | ((s >= NS) ? ((1 << NS) - 1) : ((1 << (s + 1)) - 1));
                end
            end
            frz = raw[NS-1];
            fl  = m_pending && (m_free_seen >= 1);
            e.flush  = fl;
            e.stall  = fl ? (frz ? '1 : '0) : raw[NS-1:0];
            e.bubble = '0;
            if (!fl) begin
                for (int k = 1; k < NS; k++) e.bubble[k] = e.stall[k-1] & ~e.stall[k];
            end
            e.new_pc = fl ? m_pc : '0;
            e.ack    = m_ack_next;
            e.tmo    = m_sticky;
            m_ack_next = 0;
            if (m_pending) begin
                if (!frz) begin
                    m_free_seen++;
                    if (m_free_seen == 2) m_pending = 0;
                end
            end else if (ev) begin
                m_pending   = 1;
                m_pc        = pc;
                m_free_seen = frz ? 0 : 1;
                m_ack_next  = 1;
            end
            m_run = (e.stall != 0) ? m_run + 1 : 0;
            if (m_run >= TO) m_sticky = 1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",   32'(stall),         32'(e.stall),  e.cyc);
                chk("bubble",  32'(bubble),        32'(e.bubble), e.cyc);
                chk("flush",   32'(flush),         32'(e.flush),  e.cyc);
                chk("new_pc",  new_pc,             e.new_pc,      e.cyc);
                chk("ack",     32'(excp_ack),      32'(e.ack),    e.cyc);
                chk("timeout", 32'(stall_timeout), 32'(e.tmo),    e.cyc);
            end
        end
    end

    initial begin : driver
        logic [NR*SWB-1:0] rs;
        step('0, '0, 1'b0, '0, 1'b1);
        step('0, '0, 1'b0, '0, 1'b1);
        idle(2);
        // prefix merge, then drop the deeper request
        step(4'b0011, stg(2, 4, 0, 0), 1'b0, '0, 1'b0);
        step(4'b0001, stg(2, 4, 0, 0), 1'b0, '0, 1'b0);
        // out-of-range stage index saturates
        step(4'b0100, stg(0, 0, 7, 0), 1'b0, '0, 1'b0);
        idle(1);
        // unfrozen exception
        step('0, '0, 1'b1, 32'hBFC0_0380, 1'b0);
        idle(3);
        // exception under a 3-cycle freeze, second exception ignored while pending
        step(4'b0100, stg(0, 0, 5, 0), 1'b1, 32'hAAAA_0000, 1'b0);
        step(4'b0100, stg(0, 0, 5, 0), 1'b1, 32'h0000_1234, 1'b0);
        step(4'b0100, stg(0, 0, 5, 0), 1'b0, '0, 1'b0);
        idle(4);
        // freeze arriving during the flush holds it; exception on the retiring cycle ignored
        step('0, '0, 1'b1, 32'h0000_4000, 1'b0);
        step(4'b1000, stg(0, 0, 0, 5), 1'b0, '0, 1'b0);
        step(4'b1000, stg(0, 0, 0, 5), 1'b1, 32'h0000_5000, 1'b0);
        step(4'b0001, stg(1, 0, 0, 0), 1'b1, 32'h0000_6000, 1'b0);
        idle(3);
        // watchdog: 7 cycles, gap, 8 cycles, release
        for (int i = 0; i < 7; i++) step(4'b0001, stg(1, 0, 0, 0), 1'b0, '0, 1'b0);
        idle(1);
        for (int i = 0; i < 8; i++) step(4'b0010, stg(0, 3, 0, 0), 1'b0, '0, 1'b0);
        idle(3);
        // asynchronous reset while pending discards the exception
        step(4'b0100, stg(0, 0, 5, 0), 1'b1, 32'hDEAD_BEEF, 1'b0);
        step(4'b0100, stg(0, 0, 5, 0), 1'b0, '0, 1'b0);
        step(4'b0100, stg(0, 0, 5, 0), 1'b0, '0, 1'b1);
        step(4'b0100, stg(0, 0, 5, 0), 1'b0, '0, 1'b0);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs = 12'($urandom);
            step(4'($urandom & $urandom), rs, ($urandom_range(0, 7) == 0),
                 $urandom, ($urandom_range(0, 199) == 0));
        end
        idle(2);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0, cycle);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
